// File: rtl/exec_sched_pkg.sv
// Shared encodings and defaults for the execute-stage issue/completion scheduler.
package exec_sched_pkg;

   localparam int unsigned CNT_W        = 7;
   localparam int unsigned DEF_MUL_LAT  = 3;
   localparam int unsigned DEF_DIV_LAT  = 33;
   localparam int unsigned DEF_FPU_LAT  = 4;
   localparam int unsigned DEF_FDIV_LAT = 12;

   localparam logic [4:0] FDIV_FUNCT5 = 5'b00011;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ALU  = 3'd1,
      CLS_MUL  = 3'd2,
      CLS_DIV  = 3'd3,
      CLS_FPU  = 3'd4,
      CLS_FDIV = 3'd5
   } op_class_e;

   typedef enum logic [1:0] {
      RS_ALU = 2'b00,
      RS_MDU = 2'b01,
      RS_FPU = 2'b10
   } res_sel_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } sched_state_e;

   // Result-mux leg that carries the output of a given op class.
   function automatic res_sel_e class_res_sel(input op_class_e cls);
      case (cls)
         CLS_MUL, CLS_DIV:  class_res_sel = RS_MDU;
         CLS_FPU, CLS_FDIV: class_res_sel = RS_FPU;
         default:           class_res_sel = RS_ALU;
      endcase
   endfunction

endpackage

// File: rtl/exec_lat_counter.sv
// Loadable latency down-counter; is_one_o flags the last in-flight cycle.
module exec_lat_counter
   import exec_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             is_one_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/exec_sched.sv
// Execute-stage issue/completion scheduler: classifies ops, stalls for multi-cycle units,
// drives result-select and writeback strobe. Optional counters under EXEC_SCHED_PERF_EN.
module exec_sched
   import exec_sched_pkg::*;
#(
   parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
   parameter int unsigned FPU_LAT  = DEF_FPU_LAT,
   parameter int unsigned FDIV_LAT = DEF_FDIV_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic        mul_en,
   input  logic        fpu_op,
   input  logic [2:0]  funct3,
   input  logic [4:0]  funct5,
   input  logic        flush,
   output logic [1:0]  res_sel,
   output logic        wb_valid,
   output logic        stall,
   output logic [2:0]  busy_class
`ifdef EXEC_SCHED_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] retired_ops
`endif
);

   localparam logic [CNT_W-1:0] LAT_ALU  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] LAT_FPU  = CNT_W'(FPU_LAT);
   localparam logic [CNT_W-1:0] LAT_FDIV = CNT_W'(FDIV_LAT);

   sched_state_e     state_q, state_d;
   logic             ready_q, ready_d;
   logic             stall_q, stall_d;
   logic             wb_q, wb_d;
   res_sel_e         res_sel_q, res_sel_d;
   op_class_e        busy_q, busy_d;

   op_class_e        cls_c;
   logic [CNT_W-1:0] lat_c;
   logic             accept_c;
   logic             cnt_load_c, cnt_dec_c, cnt_clear_c, cnt_is_one_c;

   // Only funct3[2] separates MUL from DIV in the MDU group.
   logic unused_funct3;
   assign unused_funct3 = ^funct3[1:0];

   // Classification; mul_en outranks fpu_op as in the datapath mux.
   always_comb begin
      cls_c = CLS_ALU;
      lat_c = LAT_ALU;
      if (mul_en) begin
         cls_c = funct3[2] ? CLS_DIV : CLS_MUL;
         lat_c = funct3[2] ? LAT_DIV : LAT_MUL;
      end else if (fpu_op) begin
         cls_c = (funct5 == FDIV_FUNCT5) ? CLS_FDIV : CLS_FPU;
         lat_c = (funct5 == FDIV_FUNCT5) ? LAT_FDIV : LAT_FPU;
      end
   end

   assign accept_c = issue_valid & ready_q & ~flush;

   always_comb begin
      state_d     = state_q;
      wb_d        = 1'b0;
      res_sel_d   = res_sel_q;
      busy_d      = busy_q;
      cnt_load_c  = 1'b0;
      cnt_dec_c   = 1'b0;
      cnt_clear_c = 1'b0;

      // Select/class fall back to idle the cycle after writeback unless re-issued.
      if (wb_q || flush) begin
         res_sel_d = RS_ALU;
         busy_d    = CLS_NONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               res_sel_d = class_res_sel(cls_c);
               busy_d    = cls_c;
               if (lat_c <= LAT_ALU) begin
                  wb_d = 1'b1;
               end else begin
                  cnt_load_c = 1'b1;
                  state_d    = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (flush) begin
               cnt_clear_c = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_dec_c = 1'b1;
               if (cnt_is_one_c) begin
                  state_d = ST_IDLE;
                  wb_d    = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
      stall_d = ~ready_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         stall_q   <= 1'b0;
         wb_q      <= 1'b0;
         res_sel_q <= RS_ALU;
         busy_q    <= CLS_NONE;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         stall_q   <= stall_d;
         wb_q      <= wb_d;
         res_sel_q <= res_sel_d;
         busy_q    <= busy_d;
      end
   end

   exec_lat_counter u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load_c),
      .dec_i      (cnt_dec_c),
      .clear_i    (cnt_clear_c),
      .load_val_i (lat_c - CNT_W'(1)),
      .is_one_o   (cnt_is_one_c)
   );

   assign issue_ready = ready_q;
   assign stall       = stall_q;
   assign wb_valid    = wb_q;
   assign res_sel     = res_sel_q;
   assign busy_class  = busy_q;

`ifdef EXEC_SCHED_PERF_EN
   logic [31:0] stall_cycles_q, retired_ops_q;

   // Flushed ops never raise wb_q, so they are never counted as retired.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         retired_ops_q  <= '0;
      end else begin
         if (stall_q) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (wb_q)    retired_ops_q  <= retired_ops_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign retired_ops  = retired_ops_q;
`endif

endmodule
